// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch buffer between the instruction memory block and decode.
// Captures read_data whenever the PC advances, holds up to DEPTH words and
// presents the head word and its decoded fields to decode.
// Optional build macro FETCHQ_STALL_CNT_EN adds a saturating queue-full stall
// counter on output stall_cnt.
module instr_fetch_queue #(
  parameter int AWIDTH = 6,
  parameter int RWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic [RWIDTH-1:0]          read_data,
  output logic [AWIDTH-1:0]          inc,
  input  logic                       flush,
  input  logic [AWIDTH-1:0]          redir_inc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RWIDTH-1:0]          out_instr,
  output logic [5:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [15:0]                out_imm,
`ifdef FETCHQ_STALL_CNT_EN
  output logic [15:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [RWIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              pop_s;
  logic              push_s;
  logic              not_full_s;

  // Handshake decode: flush suppresses both push and pop; a full queue
  // accepts a new word only when the head leaves in the same cycle.
  always_comb begin
    not_full_s = (count_r < CW'(DEPTH));
    pop_s      = (count_r != CW'(0)) & out_ready & ~flush;
    push_s     = fetch_en & ~flush & (not_full_s | pop_s);
  end

  // PC increment to the memory block; held at zero while reset is asserted.
  always_comb begin
    if (!rst) begin
      inc = AWIDTH'(0);
    end else if (flush) begin
      inc = redir_inc;
    end else if (push_s) begin
      inc = AWIDTH'(1);
    end else begin
      inc = AWIDTH'(0);
    end
  end

  // Word storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= read_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue at the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCHQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Counts cycles where fetch was wanted but the full queue refused the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (flush) begin
      stall_cnt_r <= 16'd0;
    end else if (fetch_en && !push_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  // Head presentation; fields are plain slices and meaningless when invalid.
  always_comb begin
    out_valid  = (count_r != CW'(0));
    out_instr  = mem_r[rd_ptr_r];
    out_opcode = out_instr[31:26];
    out_rs     = out_instr[25:21];
    out_rt     = out_instr[20:16];
    out_imm    = out_instr[15:0];
    count      = count_r;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue. A small instruction memory model
// (PC register plus word array) sits upstream; the stimulus process predicts
// each cycle's queue behaviour from a queue-of-words reference and pushes the
// expectations, while the monitor samples the DUT on the falling edge.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] read_data;
  logic [5:0]  inc;
  logic        flush;
  logic [5:0]  redir_inc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [15:0] out_imm;
  logic [2:0]  count;
`ifdef FETCHQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  instr_fetch_queue #(.AWIDTH(6), .RWIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .read_data  (read_data),
    .inc        (inc),
    .flush      (flush),
    .redir_inc  (redir_inc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_imm    (out_imm),
`ifdef FETCHQ_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: PC advances by inc on every rising edge.
  logic [31:0] rom [64];
  logic [5:0]  pc = 6'd0;
  assign read_data = rom[pc];
  always_ff @(posedge clk) pc <= pc + inc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: words the queue should hold, head first.
  logic [31:0] exp_q [$];
  int          cnt_q [$];
  logic [5:0]  inc_q [$];
  logic [15:0] stall_q [$];
  logic        pend_push  = 1'b0;
  logic        pend_flush = 1'b0;
  logic        pend_stall = 1'b0;
  logic [31:0] pend_word  = 32'd0;
  logic [15:0] stall_m    = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic fe, input logic rdy, input logic fl, input logic [5:0] ri);
    int   cnt;
    logic pop;
    logic push;
    logic [5:0] inc_e;
    if (pend_flush) begin
      exp_q.delete();
      stall_m = 16'd0;
    end else begin
      if (pend_push) exp_q.push_back(pend_word);
      if (pend_stall && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
    end
    cnt = exp_q.size();
    fetch_en  = fe;
    out_ready = rdy;
    flush     = fl;
    redir_inc = ri;
    pop   = (cnt > 0) && rdy && !fl;
    push  = fe && !fl && ((cnt < 4) || pop);
    inc_e = fl ? ri : (push ? 6'd1 : 6'd0);
    pend_push  = push;
    pend_word  = rom[pc];
    pend_flush = fl;
    pend_stall = fe && !fl && !push;
    cnt_q.push_back(cnt);
    inc_q.push_back(inc_e);
    stall_q.push_back(stall_m);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    fetch_en = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    pend_push = 1'b0;
    pend_flush = 1'b0;
    pend_stall = 1'b0;
    stall_m = 16'd0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares the DUT against the expectations of the current cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_count", {61'd0, count}, 64'd0);
      chk("rst_inc", {58'd0, inc}, 64'd0);
    end else if (cnt_q.size() > 0) begin
      int          c;
      logic [5:0]  ie;
      logic [15:0] se;
      logic [31:0] w;
      c  = cnt_q.pop_front();
      ie = inc_q.pop_front();
      se = stall_q.pop_front();
      chk("count", {61'd0, count}, 64'(c));
      chk("inc", {58'd0, inc}, {58'd0, ie});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (c != 0)});
`ifdef FETCHQ_STALL_CNT_EN
      chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, se});
`else
      if (se > 16'hFFFF) chk("stall_model", 64'd0, 64'd1);
`endif
      if (c > 0 && exp_q.size() > 0) begin
        w = exp_q[0];
        chk("out_instr", {32'd0, out_instr}, {32'd0, w});
        chk("fields", {22'd0, out_opcode, out_rs, out_rt, out_imm},
            {22'd0, w[31:26], w[25:21], w[20:16], w[15:0]});
        if (out_ready && !flush) void'(exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h8C22_0004;
    rst = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b0;
    flush = 1'b0;
    redir_inc = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill with decode stalled; first captured word carries known fields.
    cycle(1'b1, 1'b0, 1'b0, 6'd0);
    chk("opcode", {58'd0, out_opcode}, {58'd0, 6'h23});
    chk("rs", {59'd0, out_rs}, 64'd1);
    chk("rt", {59'd0, out_rt}, 64'd2);
    chk("imm", {48'd0, out_imm}, 64'h0004);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 6'd0);
    chk("fill_count", {61'd0, count}, 64'd4);
    chk("fill_head", {32'd0, out_instr}, 64'h8C22_0004);
    cycle(1'b1, 1'b1, 1'b0, 6'd0);
    // Drain to 3, then redirect.
    cycle(1'b0, 1'b1, 1'b0, 6'd0);
    chk("pre_flush_count", {61'd0, count}, 64'd3);
    cycle(1'b1, 1'b1, 1'b1, 6'd5);
    chk("post_flush_count", {61'd0, count}, 64'd0);
    chk("post_flush_valid", {63'd0, out_valid}, 64'd0);

    // Queue-full stall accounting.
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 6'd0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 6'd0);
`ifdef FETCHQ_STALL_CNT_EN
    chk("stall_10", {48'd0, stall_cnt}, 64'd10);
`endif
    cycle(1'b0, 1'b0, 1'b1, 6'd3);
`ifdef FETCHQ_STALL_CNT_EN
    chk("stall_flush", {48'd0, stall_cnt}, 64'd0);
`endif

    // Streaming: one word in flight.
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 6'd0);

    // Randomized traffic with occasional mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(2);
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0), 6'($urandom));
    end
    cycle(1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
